// File: rtl/id_inst_queue.sv
// rtl/id_inst_queue.sv - ID-side fetch packet FIFO with bubble drop and kill flush; optional ID_Q_BYPASS_EN
module id_inst_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             kill,
    input  logic             in_valid,
    input  logic [64:0]      in_pkt,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bp,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_inst,
    output logic [PTR_W:0]   count
);

    logic [64:0]    mem [DEPTH];
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    logic           empty;
    logic           full;
    logic           push_ok;
    logic           write;
    logic           pop;
    logic [64:0]    head;

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign in_ready = ~full;
    assign count    = wr_ptr - rd_ptr;

    // IF bubbles (inst==0) never qualify as a push.
    assign push_ok  = in_valid & in_ready & ~kill & (in_pkt[31:0] != 32'd0);
    assign pop      = ~empty & out_ready & ~kill;

`ifdef ID_Q_BYPASS_EN
    logic bypass;
    // A packet arriving at an empty queue is shown immediately; it is stored only if not taken.
    assign bypass = empty & push_ok;
    assign write  = push_ok & ~(bypass & out_ready);
`else
    assign write  = push_ok;
`endif

    // Head selection: stored head when occupied, zero when empty; kill hides validity.
    always_comb begin
        out_valid = 1'b0;
        head      = '0;
        if (!empty) begin
            head      = mem[rd_ptr[PTR_W-1:0]];
            out_valid = ~kill;
        end
`ifdef ID_Q_BYPASS_EN
        else if (bypass) begin
            head      = in_pkt;
            out_valid = 1'b1;
        end
`endif
    end

    assign out_bp   = head[64];
    assign out_pc   = head[63:32];
    assign out_inst = head[31:0];

    // Pointer update; reset beats kill, kill beats push/pop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (kill) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (write) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (reset && !kill && write) mem[wr_ptr[PTR_W-1:0]] <= in_pkt;
    end

endmodule

// File: tb/tb_id_inst_queue.sv
// tb/tb_id_inst_queue.sv - self-checking bench for id_inst_queue against a queue-based model
module tb_id_inst_queue;

    localparam int DEPTH = 4;
`ifdef ID_Q_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        kill;
    logic        in_valid;
    logic [64:0] in_pkt;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic        out_bp;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [2:0]  count;

    int vectors;
    int miscompares;

    logic [64:0] q[$];

    id_inst_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .kill(kill), .in_valid(in_valid), .in_pkt(in_pkt),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_bp(out_bp), .out_pc(out_pc), .out_inst(out_inst), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_push();
        return in_valid && (q.size() < DEPTH) && !kill && (in_pkt[31:0] != 32'd0);
    endfunction

    function automatic bit m_bypass();
        return BYP && (q.size() == 0) && m_push();
    endfunction

    function automatic bit m_valid();
        return !kill && (q.size() > 0 || m_bypass());
    endfunction

    function automatic logic [64:0] m_head();
        if (q.size() > 0) return q[0];
        if (m_bypass()) return in_pkt;
        return 65'd0;
    endfunction

    // Reference model: a plain queue updated from the pre-edge view of the inputs.
    always @(posedge clk) begin
        bit p, v;
        p = m_push();
        v = m_valid();
        if (!reset || kill) begin
            q.delete();
        end else if (q.size() > 0) begin
            if (v && out_ready) void'(q.pop_front());
            if (p) q.push_back(in_pkt);
        end else if (p && !(m_bypass() && out_ready)) begin
            q.push_back(in_pkt);
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if ($time > 6) begin
            chk("in_ready",  in_ready,  q.size() != DEPTH);
            chk("out_valid", out_valid, m_valid());
            chk("count",     count,     q.size());
            chk("out_head",  {out_bp, out_pc, out_inst}, m_head());
        end
    end

    function automatic logic [64:0] mk(input bit bp, input logic [31:0] pc, input logic [31:0] inst);
        return {bp, pc, inst};
    endfunction

    task automatic cyc(input bit rst, input bit k, input bit v, input logic [64:0] p, input bit rdy);
        @(posedge clk);
        #1;
        reset = rst; kill = k; in_valid = v; in_pkt = p; out_ready = rdy;
        @(negedge clk);
        #1;
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        reset = 1'b0; kill = 1'b0; in_valid = 1'b0; in_pkt = '0; out_ready = 1'b0;

        // 1: reset
        cyc(0, 0, 0, '0, 0);
        cyc(0, 0, 0, '0, 0);
        chk("t1_valid", out_valid, 0);
        chk("t1_pc", out_pc, 0);
        chk("t1_count", count, 0);
        chk("t1_ready", in_ready, 1);

        // 2: two packets in order
        cyc(1, 0, 1, mk(1, 32'h100, 32'h513), 1);
        cyc(1, 0, 1, mk(0, 32'h104, 32'h100093), 1);
        chk("t2_pc0", out_pc, BYP ? 32'h104 : 32'h100);
        chk("t2_bp0", out_bp, BYP ? 1'b0 : 1'b1);
        cyc(1, 0, 0, '0, 1);
        chk("t2_pc1", out_pc, BYP ? 32'h0 : 32'h104);
        cyc(1, 0, 0, '0, 1);
        chk("t2_count", count, 0);

        // 3: fill, hold 5th, drain
        for (int i = 0; i < 4; i++) cyc(1, 0, 1, mk(0, 32'h10 + 4*i, 32'h13 + i), 0);
        cyc(1, 0, 1, mk(1, 32'h50, 32'h33), 0);
        chk("t3_count", count, 4);
        chk("t3_ready", in_ready, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 0, '0, 1);
            chk("t3_drain_pc", out_pc, 32'h10 + 4*i);
            if (i == 1) chk("t3_ready_after_pop", in_ready, 1);
        end
        cyc(1, 0, 0, '0, 0);
        chk("t3_empty", count, 0);

        // 4: kill with an offered packet
        for (int i = 0; i < 3; i++) cyc(1, 0, 1, mk(0, 32'h80 + 4*i, 32'h7 + i), 0);
        cyc(1, 1, 1, mk(0, 32'h90, 32'h77), 0);
        chk("t4_kill_valid", out_valid, 0);
        cyc(1, 0, 0, '0, 0);
        chk("t4_count", count, 0);
        chk("t4_valid", out_valid, 0);

        // 5: bubble dropped, then pointer wrap
        cyc(1, 0, 1, mk(0, 32'h200, 32'h0), 0);
        cyc(1, 0, 0, '0, 0);
        chk("t5_bubble_count", count, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(1, 0, 1, mk(0, 4*i, 32'h1000 + i), 1);
            if (BYP || i > 0) chk("t5_wrap_pc", out_pc, BYP ? 4*i : 4*(i-1));
        end
        cyc(1, 0, 0, '0, 1);
        if (!BYP) chk("t5_wrap_last", out_pc, 32'h24);
        cyc(1, 0, 0, '0, 0);
        chk("t5_count", count, 0);

`ifdef ID_Q_BYPASS_EN
        // 6: bypass into empty queue
        cyc(1, 0, 1, mk(1, 32'h300, 32'h55), 1);
        chk("t6_valid", out_valid, 1);
        chk("t6_pc", out_pc, 32'h300);
        cyc(1, 0, 0, '0, 0);
        chk("t6_count", count, 0);
`endif

        // random phase
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] inst;
            inst = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            cyc(($urandom_range(0, 63) != 0), ($urandom_range(0, 31) == 0),
                ($urandom_range(0, 9) < 7), mk($urandom_range(0, 1), $urandom, inst),
                ($urandom_range(0, 2) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
